// File: rtl/serial_tx_arbiter.sv
// Two-requester frame arbiter for one serial transmitter; optional watchdog via ARB_WATCHDOG_EN.
// Latency: req to partida_serial in 2 cycles; waits on pronto_serial per byte, requests held until granted.
module serial_tx_arbiter #(
  parameter int FRAME_LEN   = 8,
  parameter int WDOG_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] dado_a,
  input  logic [7:0] dado_b,
  input  logic       pronto_serial,
  output logic       partida_serial,
  output logic [7:0] dado_serial,
  output logic [2:0] indice,
  output logic       grant_a,
  output logic       grant_b,
  output logic       fim_a,
  output logic       fim_b,
  output logic       erro_timeout,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ARBITRA = 3'd1,
    PARTIDA = 3'd2,
    ESPERA  = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5,
    ABORTA  = 3'd6
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  if (FRAME_LEN < 2 || FRAME_LEN > 8 || WDOG_CYCLES < 2) begin : g_bad_param
    $error("serial_tx_arbiter: FRAME_LEN must be 2..8 and WDOG_CYCLES >= 2");
  end

  state_t     r_state;
  logic [2:0] r_indice;
  logic       r_grant_a;
  logic       r_grant_b;
  logic       r_last_b;
  logic       r_partida;
  logic       r_fim_a;
  logic       r_fim_b;

`ifdef ARB_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
  logic [WDW-1:0] r_wdog;
  logic           r_erro;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= OCIOSO;
      r_indice  <= 3'd0;
      r_grant_a <= 1'b0;
      r_grant_b <= 1'b0;
      r_last_b  <= 1'b1;
      r_partida <= 1'b0;
      r_fim_a   <= 1'b0;
      r_fim_b   <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      r_wdog    <= '0;
      r_erro    <= 1'b0;
`endif
    end else begin
      r_partida <= 1'b0;
      r_fim_a   <= 1'b0;
      r_fim_b   <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      r_erro    <= 1'b0;
`endif
      case (r_state)
        OCIOSO: begin
          if (req_a || req_b) r_state <= ARBITRA;
        end
        ARBITRA: begin
          r_indice <= 3'd0;
          // On a tie, the side not served last wins.
          if (req_a && (!req_b || r_last_b)) begin
            r_grant_a <= 1'b1;
            r_state   <= PARTIDA;
          end else if (req_b) begin
            r_grant_b <= 1'b1;
            r_state   <= PARTIDA;
          end else begin
            r_state   <= OCIOSO;
          end
        end
        PARTIDA: begin
          r_partida <= 1'b1;
          r_state   <= ESPERA;
`ifdef ARB_WATCHDOG_EN
          r_wdog    <= '0;
`endif
        end
        ESPERA: begin
          if (pronto_serial) begin
            r_state <= (r_indice == LAST_IDX) ? FIM : PROXIMO;
`ifdef ARB_WATCHDOG_EN
          end else if (r_wdog == WDOG_LAST) begin
            r_state <= ABORTA;
          end else begin
            r_wdog  <= r_wdog + 1'b1;
`endif
          end
        end
        PROXIMO: begin
          r_indice <= r_indice + 3'd1;
          r_state  <= PARTIDA;
        end
        FIM: begin
          r_fim_a   <= r_grant_a;
          r_fim_b   <= r_grant_b;
          r_last_b  <= r_grant_b;
          r_grant_a <= 1'b0;
          r_grant_b <= 1'b0;
          r_state   <= OCIOSO;
        end
        ABORTA: begin
`ifdef ARB_WATCHDOG_EN
          r_erro    <= 1'b1;
          r_last_b  <= r_grant_b;
`endif
          r_grant_a <= 1'b0;
          r_grant_b <= 1'b0;
          r_state   <= OCIOSO;
        end
        default: begin
          r_grant_a <= 1'b0;
          r_grant_b <= 1'b0;
          r_state   <= OCIOSO;
        end
      endcase
    end
  end

  assign partida_serial = r_partida;
  assign indice         = r_indice;
  assign grant_a        = r_grant_a;
  assign grant_b        = r_grant_b;
  assign fim_a          = r_fim_a;
  assign fim_b          = r_fim_b;
  assign db_estado      = r_state;
  assign dado_serial    = r_grant_a ? dado_a : (r_grant_b ? dado_b : 8'h00);
`ifdef ARB_WATCHDOG_EN
  assign erro_timeout   = r_erro;
`else
  assign erro_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: expected bytes/pulses queued at stimulus, checked on DUT output.
module tb_serial_tx_arbiter;
  localparam int FL = 8;
  localparam int WD = 50;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_a;
  logic       req_b;
  logic [7:0] dado_a;
  logic [7:0] dado_b;
  logic       pronto_serial;
  logic       partida_serial;
  logic [7:0] dado_serial;
  logic [2:0] indice;
  logic       grant_a;
  logic       grant_b;
  logic       fim_a;
  logic       fim_b;
  logic       erro_timeout;
  logic [2:0] db_estado;

  serial_tx_arbiter #(.FRAME_LEN(FL), .WDOG_CYCLES(WD)) dut (
    .clock(clock), .reset(reset), .req_a(req_a), .req_b(req_b),
    .dado_a(dado_a), .dado_b(dado_b), .pronto_serial(pronto_serial),
    .partida_serial(partida_serial), .dado_serial(dado_serial), .indice(indice),
    .grant_a(grant_a), .grant_b(grant_b), .fim_a(fim_a), .fim_b(fim_b),
    .erro_timeout(erro_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  logic [7:0] pat_a;
  logic [7:0] pat_b;
  assign dado_a = pat_a + {5'd0, indice};
  assign dado_b = pat_b + {5'd0, indice};

  typedef struct packed {
    logic       side;
    logic [2:0] idx;
    logic [7:0] dat;
  } exp_t;

  exp_t byte_q[$];
  logic fim_q[$];
  logic erro_q[$];

  int total = 0;
  int bad = 0;
  int n_partida = 0;
  int n_fim = 0;
  int n_erro = 0;
  int cyc = 0;
  int pr_cnt = 0;
  int pr_delay = 10;
  bit pronto_en = 1'b1;
  exp_t m_e;
  logic m_side;

  // Transmitter model: answers each partida with a one-cycle pronto after pr_delay cycles.
  always @(negedge clock) begin
    pronto_serial = 1'b0;
    if (reset === 1'b1) begin
      pr_cnt = 0;
    end else if (partida_serial && pronto_en) begin
      pr_cnt = pr_delay;
    end else if (pr_cnt > 0) begin
      pr_cnt--;
      if (pr_cnt == 0) pronto_serial = 1'b1;
    end
  end

  always @(negedge clock) begin
    cyc++;
    if (reset === 1'b0) begin
      total++;
      if (grant_a && grant_b) begin
        bad++;
        $display("FAIL grant_overlap got a=%b b=%b want one-hot", grant_a, grant_b);
      end
      if (partida_serial) begin
        n_partida++;
        total++;
        if (byte_q.size() == 0) begin
          bad++;
          $display("FAIL partida_unexpected got idx=%0d dat=%h want none", indice, dado_serial);
        end else begin
          m_e = byte_q.pop_front();
          if ({grant_b, grant_a, indice, dado_serial} !== {m_e.side, ~m_e.side, m_e.idx, m_e.dat}) begin
            bad++;
            $display("FAIL byte got gb=%b ga=%b idx=%0d dat=%h want side=%0d idx=%0d dat=%h",
                     grant_b, grant_a, indice, dado_serial, m_e.side, m_e.idx, m_e.dat);
          end
        end
      end
      if (fim_a || fim_b) begin
        n_fim++;
        total++;
        if (fim_q.size() == 0) begin
          bad++;
          $display("FAIL fim_unexpected got fim_a=%b fim_b=%b want none", fim_a, fim_b);
        end else begin
          m_side = fim_q.pop_front();
          if ({fim_b, fim_a, db_estado} !== {m_side, ~m_side, 3'd0}) begin
            bad++;
            $display("FAIL fim got fim_b=%b fim_a=%b st=%0d want side=%0d st=0",
                     fim_b, fim_a, db_estado, m_side);
          end
        end
      end
      if (erro_timeout) begin
        n_erro++;
        total++;
        if (erro_q.size() == 0) begin
          bad++;
          $display("FAIL erro_unexpected got erro=1 want 0");
        end else begin
          m_side = erro_q.pop_front();
          if ({fim_a, fim_b, grant_a, grant_b} !== 4'b0) begin
            bad++;
            $display("FAIL erro_side got fim/grants=%b want 0000", {fim_a, fim_b, grant_a, grant_b});
          end
        end
      end
    end
  end

  task automatic push_frame(input logic side);
    exp_t e;
    for (int i = 0; i < FL; i++) begin
      e.side = side;
      e.idx  = 3'(i);
      e.dat  = (side ? pat_b : pat_a) + 8'(i);
      byte_q.push_back(e);
    end
    fim_q.push_back(side);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock); #1;
      if (byte_q.size() == 0 && fim_q.size() == 0 && erro_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clock); #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    pat_a = 8'h00; pat_b = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if ({db_estado, indice} !== 6'd0) begin
      bad++; $display("FAIL reset_state got st=%0d idx=%0d want 0 0", db_estado, indice);
    end
    total++;
    if ({grant_a, grant_b, partida_serial, fim_a, fim_b, erro_timeout} !== 6'd0) begin
      bad++; $display("FAIL reset_outputs got %b want 000000",
                      {grant_a, grant_b, partida_serial, fim_a, fim_b, erro_timeout});
    end
    total++;
    if (dado_serial !== 8'h00) begin
      bad++; $display("FAIL reset_dado got %h want 00", dado_serial);
    end
  endtask

  task automatic test_single_a();
    int p0;
    bit ok;
    p0 = n_partida;
    pat_a = 8'h30;
    push_frame(1'b0);
    @(negedge clock);
    req_a = 1'b1;
    @(posedge clock); // edge k
    @(posedge clock); #1;
    total++;
    if ({db_estado, partida_serial} !== {3'd2, 1'b0}) begin
      bad++; $display("FAIL latency_k1 got st=%0d partida=%b want 2 0", db_estado, partida_serial);
    end
    @(posedge clock); #1;
    total++;
    if ({partida_serial, grant_a, grant_b} !== 3'b110) begin
      bad++; $display("FAIL latency_k2 got partida/ga/gb=%b want 110", {partida_serial, grant_a, grant_b});
    end
    req_a = 1'b0;
    wait_drain(400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_a_drain got pending=%0d want 0", byte_q.size()); end
    total++;
    if (n_partida - p0 !== FL) begin
      bad++; $display("FAIL single_a_count got %0d want %0d", n_partida - p0, FL);
    end
  endtask

  task automatic test_tie();
    int f0;
    bit ok;
    do_reset();
    f0 = n_fim;
    pat_a = 8'h50; pat_b = 8'hC0;
    push_frame(1'b0); push_frame(1'b1); push_frame(1'b0); push_frame(1'b1);
    @(negedge clock);
    req_a = 1'b1; req_b = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1500 && !ok; i++) begin
      @(negedge clock); #1;
      ok = (n_fim - f0 == 3);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL tie_three_frames got %0d want 3", n_fim - f0); end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clock); #1;
      ok = grant_b;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL tie_fourth_grant got gb=%b want 1", grant_b); end
    req_a = 1'b0; req_b = 1'b0;
    wait_drain(400, ok);
    total++;
    if (!ok || n_fim - f0 !== 4) begin
      bad++; $display("FAIL tie_drain got fims=%0d pending=%0d want 4 0", n_fim - f0, byte_q.size());
    end
  endtask

  task automatic test_drop_b();
    int p0;
    bit ok;
    p0 = n_partida;
    pat_b = 8'h11;
    push_frame(1'b1);
    @(negedge clock);
    req_b = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock); #1;
      ok = (n_partida - p0 == 3);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL drop_b_third got %0d want 3", n_partida - p0); end
    req_b = 1'b0;
    wait_drain(400, ok);
    total++;
    if (!ok || n_partida - p0 !== FL) begin
      bad++; $display("FAIL drop_b_bytes got %0d want %0d", n_partida - p0, FL);
    end
  endtask

  task automatic test_reset_mid();
    int f0;
    bit ok;
    pat_a = 8'h77;
    push_frame(1'b0);
    @(negedge clock);
    req_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock); #1;
      ok = (db_estado == 3'd3 && indice == 3'd4);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL reset_mid_reach got st=%0d idx=%0d want 3 4", db_estado, indice); end
    req_a = 1'b0;
    byte_q.delete();
    fim_q.delete();
    f0 = n_fim;
    reset = 1'b1;
    @(posedge clock); #1;
    total++;
    if ({db_estado, indice} !== 6'd0) begin
      bad++; $display("FAIL reset_mid_state got st=%0d idx=%0d want 0 0", db_estado, indice);
    end
    total++;
    if ({grant_a, grant_b, fim_a, fim_b, partida_serial} !== 5'd0) begin
      bad++; $display("FAIL reset_mid_outs got %b want 00000", {grant_a, grant_b, fim_a, fim_b, partida_serial});
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    #1;
    total++;
    if (n_fim !== f0 || db_estado !== 3'd0) begin
      bad++; $display("FAIL reset_mid_quiet got fims=%0d st=%0d want 0 0", n_fim - f0, db_estado);
    end
  endtask

`ifdef ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int t0;
    int e0;
    bit ok;
    exp_t e;
    do_reset();
    pronto_en = 1'b0;
    pat_a = 8'h20; pat_b = 8'h90;
    e.side = 1'b0; e.idx = 3'd0; e.dat = 8'h20;
    byte_q.push_back(e);
    erro_q.push_back(1'b0);
    push_frame(1'b1);
    e0 = n_erro;
    @(negedge clock);
    req_a = 1'b1; req_b = 1'b1;
    t0 = 0;
    for (int i = 0; i < 20 && t0 == 0; i++) begin
      @(negedge clock); #1;
      if (db_estado == 3'd3) t0 = cyc;
    end
    ok = 1'b0;
    for (int i = 0; i < 3 * WD && !ok; i++) begin
      @(negedge clock); #1;
      ok = (n_erro != e0);
    end
    total++;
    if (!ok || cyc - t0 < WD || cyc - t0 > WD + 2) begin
      bad++; $display("FAIL wdog_timing got %0d want %0d..%0d", cyc - t0, WD, WD + 2);
    end
    total++;
    if (db_estado !== 3'd0) begin bad++; $display("FAIL wdog_state got %0d want 0", db_estado); end
    pronto_en = 1'b1;
    req_a = 1'b0;
    @(negedge clock);
    req_b = 1'b0;
    wait_drain(400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wdog_other got pending=%0d want 0", byte_q.size()); end
  endtask

  task automatic test_expiry_pronto();
    bit ok;
    pr_delay = WD - 1;
    pat_a = 8'h44;
    push_frame(1'b0);
    @(negedge clock);
    req_a = 1'b1;
    repeat (4) @(negedge clock);
    req_a = 1'b0;
    wait_drain(FL * (WD + 10), ok);
    total++;
    if (!ok) begin bad++; $display("FAIL expiry_frame got pending=%0d want 0", byte_q.size()); end
    pr_delay = 10;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_a();
    test_tie();
    test_drop_b();
    test_reset_mid();
`ifdef ARB_WATCHDOG_EN
    test_watchdog();
    test_expiry_pronto();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
